// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//
// One combinational barrel shifter (LSL / LSR / ROR / ASR) is shared by NREQ
// requesters. A round-robin arbiter picks one requester per cycle. The shifter
// result is captured in a one-entry output register, which has its own
// valid/ready handshake.
//
// Optional feature, enabled by defining the macro SHIFT_ARB_STATS_EN:
//   grant_cnt  per-requester accept counters, saturating
//   stall_cnt  count of cycles held FULL with rsp_ready low, saturating
//
// Parameters
//   NREQ    number of requesters, 2..4
//   CNT_W   width of the statistics counters
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous reset, active low
//   req_valid   [NREQ]       per-requester request valid
//   req_ready   [NREQ]       per-requester accept (one-hot or zero)
//   req_a       [NREQ*32]    operand of requester i at [32*i +: 32]
//   req_opcode  [NREQ*3]     000 LSL, 001 LSR, 010 ROR, 011 ASR, other -> 0
//   req_shamt   [NREQ*5]     shift amount
//   rsp_valid   result valid
//   rsp_ready   consumer accepts the result
//   rsp_data    [32]         shifter result
//   rsp_id      [ID_W]       requester that produced rsp_data
//   grant_cnt   [NREQ*CNT_W] (SHIFT_ARB_STATS_EN only)
//   stall_cnt   [CNT_W]      (SHIFT_ARB_STATS_EN only)
// -----------------------------------------------------------------------------
module shift_arbiter #(
    parameter int NREQ  = 2,
    parameter int CNT_W = 16,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*32-1:0]    req_a,
    input  logic [NREQ*3-1:0]     req_opcode,
    input  logic [NREQ*5-1:0]     req_shamt,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [ID_W-1:0]       rsp_id
`ifdef SHIFT_ARB_STATS_EN
    ,
    output logic [NREQ*CNT_W-1:0] grant_cnt,
    output logic [CNT_W-1:0]      stall_cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;   // last winner; the search starts just after it
    logic [ID_W-1:0] win;
    logic            any_valid;
    logic            can_accept;
    logic            accept;

    function automatic logic [31:0] shifter(input logic [31:0] a,
                                            input logic [2:0]  op,
                                            input logic [4:0]  sh);
        logic [63:0] dbl;
        dbl = {a, a} >> sh;    // rotate: the low half of the doubled word
        case (op)
            3'b000:  return a << sh;
            3'b001:  return a >> sh;
            3'b010:  return dbl[31:0];
            3'b011:  return 32'($signed(a) >>> sh);
            default: return 32'h0;
        endcase
    endfunction

    // Round-robin search from rr_ptr+1 (mod NREQ); the first valid bit wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        win       = '0;
        any_valid = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                win       = ID_W'(idx);
            end
        end
    end

    // The output register can take new data when it is empty or being drained
    // in this same cycle.
    assign can_accept = (state == EMPTY) || rsp_ready;
    assign accept     = any_valid && can_accept;
    assign req_ready  = accept ? ({{(NREQ-1){1'b0}}, 1'b1} << win) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rr_ptr    <= ID_W'(NREQ - 1);
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            if (accept) begin
                rsp_data  <= shifter(req_a[32*win +: 32],
                                     req_opcode[3*win +: 3],
                                     req_shamt[5*win +: 5]);
                rsp_id    <= win;
                rr_ptr    <= win;
                state     <= FULL;
                rsp_valid <= 1'b1;
            end else if (state == FULL && rsp_ready) begin
                // Drained with nothing to replace it; data and id hold.
                state     <= EMPTY;
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef SHIFT_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (accept && win == ID_W'(i) &&
                    grant_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})
                    grant_cnt[i*CNT_W +: CNT_W] <= grant_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
            if (state == FULL && !rsp_ready && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
